// File: rtl/legv8_pkg.sv
// LEGv8 shared constants: register/data widths, zero-register index
// and load-size encodings.
package legv8_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   localparam logic [4:0] XZR_IDX = 5'd31;

   typedef enum logic [1:0] {
      LD_BYTE   = 2'b00,
      LD_HALF   = 2'b01,
      LD_WORD   = 2'b10,
      LD_DOUBLE = 2'b11
   } ld_size_e;

endpackage

// File: rtl/wb_load_align.sv
// Load sizing: keeps the low byte/half/word/double of a memory word
// and zero- or sign-extends it to DATA_W.
module wb_load_align
   import legv8_pkg::*;
#(
   parameter int DATA_W = legv8_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        size,
   input  logic              sgn,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = data;
      unique case (size)
         LD_BYTE:
            result = {{(DATA_W-8){sgn & data[7]}},
                      data[7:0]};
         LD_HALF:
            result = {{(DATA_W-16){sgn & data[15]}},
                      data[15:0]};
         LD_WORD:
            result = {{(DATA_W-32){sgn & data[31]}},
                      data[31:0]};
         LD_DOUBLE:
            result = data;
         default:
            result = data;
      endcase
   end

endmodule

// File: rtl/wb_writeback_unit.sv
// LEGv8 write-back unit: 2-entry skid queue feeding the register-file
// write port. Define WB_PERF_COUNT_EN to add retire/write counters.
module wb_writeback_unit
   import legv8_pkg::*;
#(
   parameter int DATA_W = legv8_pkg::DATA_W,
   parameter int ADDR_W = legv8_pkg::ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_reg_write,
   input  logic              in_mem_to_reg,
   input  logic [ADDR_W-1:0] in_write_reg,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [1:0]        in_load_size,
   input  logic              in_load_signed,
   input  logic              wb_stall,
   output logic              REG_WRITE,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] writeData,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_reg,
   output logic [DATA_W-1:0] fwd_data,
`ifdef WB_PERF_COUNT_EN
   output logic [63:0]       retire_count,
   output logic [63:0]       write_count,
`endif
   output logic              retired
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0]  q_we;
   logic [ADDR_W-1:0] q_reg  [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] in_result;

   logic head_valid;
   logic head_real;
   logic push;
   logic pop;

   wb_load_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .data   (in_mem_data),
      .size   (in_load_size),
      .sgn    (in_load_signed),
      .result (ld_data)
   );

   assign in_result = in_mem_to_reg ? ld_data : in_alu_result;

   assign in_ready   = (count < CW'(DEPTH));
   assign head_valid = (count != '0);
   assign push       = in_valid && in_ready;
   assign pop        = head_valid && !wb_stall;

   // Entries targeting XZR or not writing still drain through the queue.
   assign head_real = head_valid && q_we[rd_ptr] &&
                      (q_reg[rd_ptr] != ADDR_W'(XZR_IDX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         q_we   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_reg[i]  <= '0;
            q_data[i] <= '0;
         end
      end else begin
         if (push) begin
            q_we[wr_ptr]   <= in_reg_write;
            q_reg[wr_ptr]  <= in_write_reg;
            q_data[wr_ptr] <= in_result;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      REG_WRITE = head_real && !wb_stall;
      fwd_valid = head_real;
      retired   = pop;
      write_reg = '0;
      writeData = '0;
      if (head_valid) begin
         write_reg = q_reg[rd_ptr];
         writeData = q_data[rd_ptr];
      end
      fwd_reg  = write_reg;
      fwd_data = writeData;
   end

`ifdef WB_PERF_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_count <= '0;
         write_count  <= '0;
      end else begin
         if (pop) begin
            retire_count <= retire_count + 64'd1;
         end
         if (REG_WRITE) begin
            write_count <= write_count + 64'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: ALU/load writes, sizing,
// XZR suppression, backpressure and asynchronous reset.
module tb_wb_writeback_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic        in_mem_to_reg;
   logic [4:0]  in_write_reg;
   logic [63:0] in_alu_result;
   logic [63:0] in_mem_data;
   logic [1:0]  in_load_size;
   logic        in_load_signed;
   logic        wb_stall;
   logic        REG_WRITE;
   logic [4:0]  write_reg;
   logic [63:0] writeData;
   logic        fwd_valid;
   logic [4:0]  fwd_reg;
   logic [63:0] fwd_data;
   logic        retired;
`ifdef WB_PERF_COUNT_EN
   logic [63:0] retire_count;
   logic [63:0] write_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_writeback_unit dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_reg_write   (in_reg_write),
      .in_mem_to_reg  (in_mem_to_reg),
      .in_write_reg   (in_write_reg),
      .in_alu_result  (in_alu_result),
      .in_mem_data    (in_mem_data),
      .in_load_size   (in_load_size),
      .in_load_signed (in_load_signed),
      .wb_stall       (wb_stall),
      .REG_WRITE      (REG_WRITE),
      .write_reg      (write_reg),
      .writeData      (writeData),
      .fwd_valid      (fwd_valid),
      .fwd_reg        (fwd_reg),
      .fwd_data       (fwd_data),
`ifdef WB_PERF_COUNT_EN
      .retire_count   (retire_count),
      .write_count    (write_count),
`endif
      .retired        (retired)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one instruction from negedge, enqueue at posedge, sample #1 later.
   task automatic push(input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] mem, input logic [1:0] sz,
                       input logic sg);
      @(negedge clk);
      in_valid       = 1'b1;
      in_reg_write   = rw;
      in_mem_to_reg  = m2r;
      in_write_reg   = rd;
      in_alu_result  = alu;
      in_mem_data    = mem;
      in_load_size   = sz;
      in_load_signed = sg;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_reg_write = 1'b0;
      in_mem_to_reg = 1'b0;
      in_write_reg = '0;
      in_alu_result = '0;
      in_mem_data = '0;
      in_load_size = '0;
      in_load_signed = 1'b0;
      wb_stall = 1'b0;
      #12;
      check("rst_reg_write", 64'(REG_WRITE), 64'd0);
      check("rst_write_reg", 64'(write_reg), 64'd0);
      check("rst_write_data", writeData, 64'd0);
      check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      check("rst_retired", 64'(retired), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;

      // ALU write
      push(1, 0, 5'd5, 64'h1234, 64'h0, 2'b00, 0);
      check("alu_reg_write", 64'(REG_WRITE), 64'd1);
      check("alu_write_reg", 64'(write_reg), 64'd5);
      check("alu_write_data", writeData, 64'h1234);
      check("alu_retired", 64'(retired), 64'd1);
      check("alu_fwd_valid", 64'(fwd_valid), 64'd1);
      check("alu_fwd_data", fwd_data, 64'h1234);
      idle_cycle();
      check("empty_reg_write", 64'(REG_WRITE), 64'd0);
      check("empty_retired", 64'(retired), 64'd0);
      check("empty_fwd_valid", 64'(fwd_valid), 64'd0);

      // Load sizing
      push(1, 1, 5'd9, 64'h0, 64'h0000_0000_0000_00F0, 2'b00, 1);
      check("ldsb_data", writeData, 64'hFFFF_FFFF_FFFF_FFF0);
      check("ldsb_reg", 64'(write_reg), 64'd9);
      push(1, 1, 5'd9, 64'h0, 64'h0000_0000_0000_00F0, 2'b00, 0);
      check("ldub_data", writeData, 64'h0000_0000_0000_00F0);
      push(1, 1, 5'd10, 64'h0, 64'h1234_5678_9ABC_8001, 2'b01, 1);
      check("ldsh_data", writeData, 64'hFFFF_FFFF_FFFF_8001);
      push(1, 1, 5'd10, 64'h0, 64'h1234_5678_9ABC_8001, 2'b01, 0);
      check("lduh_data", writeData, 64'h0000_0000_0000_8001);
      push(1, 1, 5'd11, 64'h0, 64'hAAAA_AAAA_8000_0000, 2'b10, 1);
      check("ldsw_data", writeData, 64'hFFFF_FFFF_8000_0000);
      push(1, 1, 5'd11, 64'h0, 64'hAAAA_AAAA_8000_0000, 2'b10, 0);
      check("lduw_data", writeData, 64'h0000_0000_8000_0000);
      push(1, 1, 5'd12, 64'h0, 64'h8000_0000_0000_0001, 2'b11, 1);
      check("ldd_data", writeData, 64'h8000_0000_0000_0001);
      push(1, 0, 5'd13, 64'hFFFF_0000_0000_00F0, 64'h7F, 2'b00, 1);
      check("alu_ignores_size", writeData, 64'hFFFF_0000_0000_00F0);

      // XZR and non-writing entries still retire
      push(1, 0, 5'd31, 64'hDEAD, 64'h0, 2'b00, 0);
      check("xzr_reg_write", 64'(REG_WRITE), 64'd0);
      check("xzr_fwd_valid", 64'(fwd_valid), 64'd0);
      check("xzr_retired", 64'(retired), 64'd1);
      check("xzr_write_reg", 64'(write_reg), 64'd31);
      push(0, 0, 5'd7, 64'h55, 64'h0, 2'b00, 0);
      check("nowr_reg_write", 64'(REG_WRITE), 64'd0);
      check("nowr_retired", 64'(retired), 64'd1);
      check("nowr_write_reg", 64'(write_reg), 64'd7);
      idle_cycle();

      // Backpressure
      @(negedge clk);
      wb_stall = 1'b1;
      push(1, 0, 5'd1, 64'h11, 64'h0, 2'b00, 0);
      check("bp1_in_ready", 64'(in_ready), 64'd1);
      check("bp1_reg_write", 64'(REG_WRITE), 64'd0);
      check("bp1_fwd_valid", 64'(fwd_valid), 64'd1);
      check("bp1_fwd_reg", 64'(fwd_reg), 64'd1);
      check("bp1_retired", 64'(retired), 64'd0);
      push(1, 0, 5'd2, 64'h22, 64'h0, 2'b00, 0);
      check("bp2_in_ready", 64'(in_ready), 64'd0);
      check("bp2_fwd_reg", 64'(fwd_reg), 64'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_reg_write = 1'b1;
      in_mem_to_reg = 1'b0;
      in_write_reg = 5'd3;
      in_alu_result = 64'h33;
      @(posedge clk);
      #1;
      check("bp3_in_ready", 64'(in_ready), 64'd0);
      check("bp3_fwd_reg", 64'(fwd_reg), 64'd1);
      @(negedge clk);
      wb_stall = 1'b0;
      #1;
      check("rel1_reg_write", 64'(REG_WRITE), 64'd1);
      check("rel1_write_reg", 64'(write_reg), 64'd1);
      check("rel1_write_data", writeData, 64'h11);
      @(posedge clk);
      #1;
      check("rel2_reg_write", 64'(REG_WRITE), 64'd1);
      check("rel2_write_reg", 64'(write_reg), 64'd2);
      check("rel2_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("rel3_reg_write", 64'(REG_WRITE), 64'd1);
      check("rel3_write_reg", 64'(write_reg), 64'd3);
      check("rel3_write_data", writeData, 64'h33);
      idle_cycle();
      check("rel_empty", 64'(REG_WRITE), 64'd0);

      // Asynchronous reset mid-operation
      @(negedge clk);
      wb_stall = 1'b1;
      push(1, 0, 5'd4, 64'h44, 64'h0, 2'b00, 0);
      push(1, 0, 5'd6, 64'h66, 64'h0, 2'b00, 0);
      check("pre_rst_fwd_reg", 64'(fwd_reg), 64'd4);
      #2;
      reset = 1'b1;
      #1;
      check("mrst_reg_write", 64'(REG_WRITE), 64'd0);
      check("mrst_write_reg", 64'(write_reg), 64'd0);
      check("mrst_write_data", writeData, 64'd0);
      check("mrst_fwd_valid", 64'(fwd_valid), 64'd0);
      check("mrst_retired", 64'(retired), 64'd0);
      check("mrst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      wb_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_no_write", 64'(REG_WRITE), 64'd0);
         check("post_rst_no_retire", 64'(retired), 64'd0);
      end

`ifdef WB_PERF_COUNT_EN
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("perf_rst_retire", retire_count, 64'd0);
      check("perf_rst_write", write_count, 64'd0);
      push(1, 0, 5'd1, 64'h1, 64'h0, 2'b00, 0);
      push(1, 0, 5'd2, 64'h2, 64'h0, 2'b00, 0);
      push(1, 0, 5'd31, 64'h3, 64'h0, 2'b00, 0);
      push(1, 0, 5'd3, 64'h4, 64'h0, 2'b00, 0);
      idle_cycle();
      check("perf_retire_count", retire_count, 64'd4);
      check("perf_write_count", write_count, 64'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
